// File: rtl/mult_scheduler_if.sv
// Request/grant and result bus of the shared-multiplier scheduler.
// The requester side drives operands; the scheduler returns grants and per-channel results.
interface mult_scheduler_if #(
  parameter int BITSIZE = 16,
  parameter int NCH     = 4
);
  logic [NCH-1:0]         req;
  logic [NCH*BITSIZE-1:0] in_a;
  logic [NCH*BITSIZE-1:0] in_b;
  logic [NCH-1:0]         gnt;
  logic [NCH*BITSIZE-1:0] out_data;
  logic [NCH-1:0]         out_valid;
  logic                   frame_done;
  logic                   overrun;

  modport master (
    output req, in_a, in_b,
    input  gnt, out_data, out_valid, frame_done, overrun
  );

  modport slave (
    input  req, in_a, in_b,
    output gnt, out_data, out_valid, frame_done, overrun
  );
endinterface

// File: rtl/mult_scheduler.sv
// Frame-synchronous round-robin scheduler time-sharing one signed Q1.x multiplier
// among NCH channels; results are truncated, with the single -1 x -1 overflow saturated.
module mult_scheduler #(
  parameter int BITSIZE = 16,
  parameter int NCH     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lrclk,
  mult_scheduler_if.slave   bus
);
  localparam int PTR_W  = $clog2(NCH);
  localparam int PROD_W = 2 * BITSIZE;

  typedef enum logic [1:0] {IDLE, ARB, DRAIN} state_t;

  state_t                    state_q, state_d;
  logic                      lrclk_meta, lrclk_sync, lrclk_prev;
  logic                      lrclk_live, arm;
  logic                      frame_start;
  logic [NCH-1:0]            pending_q, pending_d;
  logic [PTR_W-1:0]          ptr_q, ptr_d;
  logic                      drain_cnt_q, drain_cnt_d;
  logic                      grant_any, issue;
  logic [PTR_W-1:0]          grant_idx;
  logic [NCH-1:0]            grant_vec;
  logic                      done_empty, done_drain, done_p;
  logic [NCH-1:0]            gnt_q;
  logic                      vld_p1, vld_p2;
  logic [PTR_W-1:0]          tag_p1, tag_p2;
  logic signed [BITSIZE-1:0] a_p1, b_p1;
  logic signed [PROD_W-1:0]  product_p2;
  logic [NCH*BITSIZE-1:0]    out_data_q;
  logic [NCH-1:0]            out_valid_q;
  logic                      frame_done_q, overrun_q;

  // The only product whose magnitude reaches 2^(2*BITSIZE-2) is (-1)x(-1);
  // its top two bits read 01 and it is clamped to the largest positive value.
  function automatic logic signed [BITSIZE-1:0] sat_trunc(input logic signed [PROD_W-1:0] p);
    if (p[PROD_W-1:PROD_W-2] == 2'b01)
      return {1'b0, {(BITSIZE-1){1'b1}}};
    return p[PROD_W-2:BITSIZE-1];
  endfunction

  // arm blocks a false frame start when lrclk is already high as reset releases.
  assign frame_start = lrclk_sync & ~lrclk_prev & arm;

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    ptr_d       = ptr_q;
    drain_cnt_d = drain_cnt_q;
    grant_any   = 1'b0;
    grant_idx   = '0;
    grant_vec   = '0;
    issue       = 1'b0;
    done_empty  = 1'b0;
    done_drain  = 1'b0;

    for (int k = 0; k < NCH; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!grant_any && pending_q[idx]) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'(idx);
      end
    end

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          pending_d = bus.req;
          if (bus.req != '0) state_d = ARB;
          else               done_empty = 1'b1;
        end
      end
      ARB: begin
        if (grant_any) begin
          issue                = 1'b1;
          grant_vec            = NCH'(1) << grant_idx;
          pending_d[grant_idx] = 1'b0;
          ptr_d = (grant_idx == PTR_W'(NCH - 1)) ? '0 : grant_idx + 1'b1;
          if ((pending_q & ~grant_vec) == '0) begin
            state_d     = DRAIN;
            drain_cnt_d = 1'b0;
          end
        end else begin
          state_d     = DRAIN;
          drain_cnt_d = 1'b0;
        end
      end
      DRAIN: begin
        drain_cnt_d = 1'b1;
        if (drain_cnt_q) begin
          state_d    = IDLE;
          done_drain = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lrclk_meta   <= 1'b0;
      lrclk_sync   <= 1'b0;
      lrclk_prev   <= 1'b0;
      lrclk_live   <= 1'b0;
      arm          <= 1'b0;
      state_q      <= IDLE;
      pending_q    <= '0;
      ptr_q        <= '0;
      drain_cnt_q  <= 1'b0;
      gnt_q        <= '0;
      vld_p1       <= 1'b0;
      tag_p1       <= '0;
      vld_p2       <= 1'b0;
      tag_p2       <= '0;
      out_valid_q  <= '0;
      out_data_q   <= '0;
      done_p       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      lrclk_meta  <= lrclk;
      lrclk_sync  <= lrclk_meta;
      lrclk_prev  <= lrclk_sync;
      lrclk_live  <= 1'b1;
      if (lrclk_live && !lrclk_meta) arm <= 1'b1;
      state_q     <= state_d;
      pending_q   <= pending_d;
      ptr_q       <= ptr_d;
      drain_cnt_q <= drain_cnt_d;
      gnt_q       <= grant_vec;
      // stage 1: channel tag travels with the captured operands
      vld_p1      <= issue;
      if (issue) tag_p1 <= grant_idx;
      // stage 2: product register
      vld_p2      <= vld_p1;
      tag_p2      <= tag_p1;
      // stage 3: result write-back
      out_valid_q <= vld_p2 ? (NCH'(1) << tag_p2) : '0;
      if (vld_p2) out_data_q[tag_p2*BITSIZE +: BITSIZE] <= sat_trunc(product_p2);
      done_p       <= done_drain;
      frame_done_q <= done_empty | done_p;
      overrun_q    <= frame_start && (state_q != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    // stage 1: operand capture
    if (issue) begin
      a_p1 <= bus.in_a[grant_idx*BITSIZE +: BITSIZE];
      b_p1 <= bus.in_b[grant_idx*BITSIZE +: BITSIZE];
    end
    // stage 2: full-width signed product
    product_p2 <= PROD_W'(a_p1) * PROD_W'(b_p1);
  end

  assign bus.gnt        = gnt_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_mult_scheduler.sv
// Directed, table-driven bench for mult_scheduler (BITSIZE=16, NCH=4) with
// hand-written sequences for the reset and overrun corner cases.
module tb_mult_scheduler;
  logic clk = 1'b0;
  logic reset;
  logic lrclk;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  mult_scheduler_if #(.BITSIZE(16), .NCH(4)) bus ();

  mult_scheduler #(.BITSIZE(16), .NCH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .lrclk (lrclk),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  req;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp_out;
    int          ngnt;
    logic [15:0] order;
    logic        glitch;
  } vec_t;

  vec_t vec [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input int n);
    int t0, ng, nv, nd, novr, d_cyc, onehot_bad;
    int g_ch [4];
    int g_cyc [4];
    int v_cyc [4];
    vec_t v;
    v = vec[n];
    ng = 0; nv = 0; nd = 0; novr = 0; d_cyc = -1; onehot_bad = 0;
    for (int c = 0; c < 4; c++) begin g_ch[c] = -1; g_cyc[c] = -1; v_cyc[c] = -1; end
    @(negedge clk);
    bus.req  = v.req;
    bus.in_a = v.a;
    bus.in_b = v.b;
    lrclk    = 1'b1;
    t0 = cyc;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (|bus.gnt) begin
        if ($countones(bus.gnt) != 1) onehot_bad++;
        if (ng < 4) begin
          for (int c = 0; c < 4; c++) if (bus.gnt[c]) g_ch[ng] = c;
          g_cyc[ng] = cyc;
        end
        ng++;
      end
      for (int c = 0; c < 4; c++) if (bus.out_valid[c]) begin nv++; v_cyc[c] = cyc; end
      if (bus.frame_done) begin nd++; d_cyc = cyc; end
      if (bus.overrun) novr++;
      if (i == 4) bus.req = ~v.req;
      if (v.glitch && i == 1) lrclk = 1'b0;
      if (v.glitch && i == 3) lrclk = 1'b1;
      if (i == 6) lrclk = 1'b0;
    end
    check($sformatf("v%0d ngnt", n), ng, v.ngnt);
    check($sformatf("v%0d onehot", n), onehot_bad, 0);
    for (int k = 0; k < v.ngnt && k < 4; k++) begin
      check($sformatf("v%0d order[%0d]", n, k), g_ch[k], v.order[k*4 +: 4]);
      check($sformatf("v%0d gnt_cycle[%0d]", n, k), g_cyc[k] - t0, 4 + k);
      if (g_ch[k] >= 0)
        check($sformatf("v%0d valid_lat[%0d]", n, k), v_cyc[g_ch[k]] - g_cyc[k], 2);
    end
    check($sformatf("v%0d nvalid", n), nv, v.ngnt);
    check($sformatf("v%0d ndone", n), nd, 1);
    check($sformatf("v%0d done_cycle", n), d_cyc - t0, (v.ngnt == 0) ? 3 : v.ngnt + 6);
    check($sformatf("v%0d overrun", n), novr, v.glitch ? 1 : 0);
    check($sformatf("v%0d out_data", n), bus.out_data, v.exp_out);
  endtask

  initial begin
    int t0, cnt;
    bit seen;
    //          req      a                       b                       exp_out                 n  order     glitch
    vec[0] = '{4'b0101, 64'h1234_8000_1234_4000, 64'h1234_4000_1234_4000, 64'h0000_C000_0000_2000, 2, 16'h0020, 1'b0};
    vec[1] = '{4'b0001, 64'h1234_1234_1234_8000, 64'h1234_1234_1234_8000, 64'h0000_C000_0000_7FFF, 1, 16'h0000, 1'b0};
    vec[2] = '{4'b0001, 64'h1234_1234_1234_7FFF, 64'h1234_1234_1234_8000, 64'h0000_C000_0000_8001, 1, 16'h0000, 1'b0};
    vec[3] = '{4'b1111, 64'hFFFF_C000_7FFF_2000, 64'h0001_4000_7FFF_2000, 64'hFFFF_E000_7FFE_0800, 4, 16'h0321, 1'b0};
    vec[4] = '{4'b0000, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'hFFFF_E000_7FFE_0800, 0, 16'h0000, 1'b0};
    vec[5] = '{4'b1001, 64'h8000_1234_1234_4000, 64'h8000_1234_1234_8000, 64'h7FFF_E000_7FFE_C000, 2, 16'h0003, 1'b0};
    vec[6] = '{4'b1111, 64'hFFFF_C000_7FFF_2000, 64'h0001_4000_7FFF_2000, 64'hFFFF_E000_7FFE_0800, 4, 16'h0321, 1'b1};
    vec[7] = '{4'b0110, 64'h1234_4000_2000_1234, 64'h1234_4000_2000_1234, 64'h0000_2000_0800_0000, 2, 16'h0021, 1'b0};

    // Reset with lrclk already high: no frame may start until lrclk goes low and rises again.
    reset = 1'b1; lrclk = 1'b1;
    bus.req = '0; bus.in_a = '0; bus.in_b = '0;
    repeat (3) @(negedge clk);
    check("reset out_data", bus.out_data, 64'h0);
    check("reset ctrl", {bus.gnt, bus.out_valid, bus.frame_done, bus.overrun}, 10'h0);
    reset = 1'b0;
    bus.req = 4'b1111;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if ((|bus.gnt) || bus.frame_done || bus.overrun) cnt++;
    end
    check("no start with lrclk high", cnt, 0);
    lrclk = 1'b0;
    repeat (4) @(negedge clk);

    for (int n = 0; n < 7; n++) run_frame(n);

    // Reset for one cycle right after the first grant of a full frame.
    @(negedge clk);
    bus.req = 4'b1111; bus.in_a = vec[3].a; bus.in_b = vec[3].b;
    lrclk = 1'b1;
    t0 = cyc;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (|bus.gnt) seen = 1'b1;
    end
    check("rst frame first gnt", {31'd0, seen}, 1);
    check("rst frame gnt cycle", cyc - t0, 4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    lrclk = 1'b0;
    check("midreset out_data", bus.out_data, 64'h0);
    check("midreset ctrl", {bus.gnt, bus.out_valid, bus.frame_done, bus.overrun}, 10'h0);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if ((|bus.out_valid) || bus.frame_done || (|bus.gnt)) cnt++;
    end
    check("post reset quiet", cnt, 0);

    run_frame(7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mult_scheduler.md
MULT_SCHEDULER -- requirements
Module: mult_scheduler

Interface
REQ-001 Parameter BITSIZE, default 16: sample and operand width, signed two's complement, Q1.(BITSIZE-1).
REQ-002 Parameter NCH, default 4: number of requesting channels sharing one multiplier; range 2..8.
REQ-003 Port clk, input, 1: single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port reset, input, 1: synchronous reset, active-high.
REQ-005 Port lrclk, input, 1: audio frame clock, asynchronous to clk.
REQ-006 Port req, input, NCH: per-channel multiply request level.
REQ-007 Port in_a, input, NCH*BITSIZE: packed operand A; channel i occupies [i*BITSIZE +: BITSIZE].
REQ-008 Port in_b, input, NCH*BITSIZE: packed operand B, same packing as in_a.
REQ-009 Port gnt, output, NCH: one-hot, one-cycle pulse on the cycle channel i's operands are captured.
REQ-010 Port out_data, output, NCH*BITSIZE: registered per-channel results, same packing as in_a.
REQ-011 Port out_valid, output, NCH: one-cycle pulse per channel when its out_data slice updates.
REQ-012 Port frame_done, output, 1: one-cycle pulse when all requests latched for a frame are retired.
REQ-013 Port overrun, output, 1: one-cycle pulse when a frame start arrives while the scheduler is not IDLE.

Function
REQ-014 lrclk SHALL pass through a 2-FF synchronizer; a frame start is a rising edge of the synchronized signal.
REQ-015 The FSM SHALL have the states IDLE, ARB and DRAIN.
REQ-016 On a frame start in IDLE: pending <= req; next state ARB if req != 0, else frame_done pulses on the next cycle and the FSM stays in IDLE.
REQ-017 The first gnt SHALL assert exactly 3 clk cycles after the first clk edge that samples lrclk high.
REQ-018 ARB: each cycle, grant exactly one pending channel, round-robin, searching upward from ptr and wrapping modulo NCH.
REQ-019 On a grant to channel i: capture in_a[i] and in_b[i] into stage-1 registers, clear pending[i], and set ptr <= (i+1) mod NCH.
REQ-020 Grants SHALL issue back-to-back with no idle cycles; req changes after the frame start SHALL NOT alter pending.
REQ-021 When pending becomes empty, go to DRAIN; after 2 cycles, go to IDLE with a frame_done pulse.
REQ-022 frame_done SHALL pulse on the cycle after the last out_valid.
REQ-023 Pipeline: stage 1 = operand and channel-tag registers; stage 2 = full 2*BITSIZE signed product register; stage 3 = out_data[tag] write.
REQ-024 out_valid[i] SHALL pulse exactly 2 cycles after gnt[i].
REQ-025 Result = product[2*BITSIZE-2 : BITSIZE-1], truncated.
REQ-026 Sole exception to REQ-025: (-2^(BITSIZE-1)) x (-2^(BITSIZE-1)) SHALL saturate to 2^(BITSIZE-1)-1.
REQ-027 out_data slices SHALL hold their value until rewritten; un-granted channels keep their previous result.
REQ-028 Frame start in ARB or DRAIN: pulse overrun, ignore the new frame, and continue the current frame unchanged.
REQ-029 ptr SHALL persist across frames.

Reset
REQ-030 While reset is high at a clk edge, the following SHALL be cleared: FSM->IDLE, ptr=0, pending=0, synchronizer and edge-detect registers=0, pipeline valid/tag=0, gnt=0, out_valid=0, out_data=0, frame_done=0, overrun=0.
REQ-031 Reset mid-frame SHALL discard in-flight products: no out_valid and no frame_done after reset deasserts.
REQ-032 A frame start SHALL NOT be detected on the first edge after reset if lrclk is already high; a rising edge is required.

Verification (BITSIZE=16, NCH=4)
REQ-033 Reset; lrclk rises; req=0101, a0=b0=0x4000, a2=0x8000, b2=0x4000 -> gnt=0001 then 0100 on consecutive cycles; out0=0x2000, out2=0xC000, each valid 2 cycles after its gnt; frame_done 1 cycle after the last valid.
REQ-034 req=0001, a0=b0=0x8000 -> out0=0x7FFF (saturated); a0=0x7FFF, b0=0x8000 -> out0=0x8001.
REQ-035 Frame 1 req=0001 (ptr->1); frame 2 req=1111 -> grant order ch1, ch2, ch3, ch0; ptr=1 afterwards.
REQ-036 req=0000 at frame start -> no gnt, no out_valid; single frame_done pulse; out_data unchanged.
REQ-037 req=1111; second lrclk rising edge reaches the synchronizer during ARB -> one overrun pulse, exactly 4 grants, one frame_done.
REQ-038 Reset asserted for 1 cycle right after the first gnt of a req=1111 frame -> all outputs 0; no out_valid or frame_done until the next frame start.
